// File: rtl/aes128_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes128_dsp_pkg
// Purpose  : Shared AES-128 DSP datapath constants, state type and byte-index helper.
// Revision : 1.0
// ============================================================================
package aes128_dsp_pkg;

   localparam int AES_NB   = 4;
   localparam int AES_ROWS = 4;

   typedef logic [127:0] aes_state_t;

   // LSB position of column k, row r; column 0 / row 0 occupy the MSB byte.
   function automatic int col_row_lsb(input int k, input int r);
      return 127 - 32*k - 8*r - 7;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_dsp_u_skewreg.sv
`default_nettype none
// ============================================================================
// Module   : aes128_dsp_u_skewreg
// Purpose  : Byte-wide shift register of DEPTH stages, advancing only on EN.
// Revision : 1.0
// ============================================================================
module aes128_dsp_u_skewreg #(
   parameter int DEPTH = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic [7:0] DIN,
   output logic [7:0] DOUT
);

   logic [7:0] r_sr [DEPTH];

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else if (EN) begin
         r_sr[0] <= DIN;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign DOUT = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/aes128_dsp_u_invperm.sv
`default_nettype none
// ============================================================================
// Module   : aes128_dsp_u_invperm
// Purpose  : Skewed InvShiftRows; row r is taken from the beat accepted r beats earlier.
//            Option macro AES128_INVPERM_ZERO_FILL_EN emits priming beats with zero rows.
// Revision : 1.0
// ============================================================================
module aes128_dsp_u_invperm
   import aes128_dsp_pkg::*;
#(
   parameter int SKEW_ROWS = 3
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         FLUSH,
   input  logic [127:0] DIN,
   input  logic         IN_VALID,
   output logic         IN_READY,
   output logic [127:0] DOUT,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic         PRIMED
);

   if (SKEW_ROWS != 3) begin : g_bad_skew
      $error("aes128_dsp_u_invperm: only SKEW_ROWS = 3 is supported");
   end

   logic [1:0] r_fill;
   logic       w_primed;
   logic       w_flush;
   logic       w_clr;
   logic       w_in_ready;
   logic       w_acc;
   logic [7:0] w_sr_q [AES_NB][SKEW_ROWS];

   assign w_primed = (r_fill == 2'd3);
   assign w_flush  = FLUSH & ~RST;
   assign w_clr    = RST | FLUSH;
   assign w_acc    = IN_VALID & w_in_ready;

`ifdef AES128_INVPERM_ZERO_FILL_EN
   assign w_in_ready = ~w_flush & OUT_READY;
   assign OUT_VALID  = IN_VALID;
`else
   assign w_in_ready = ~w_flush & (w_primed ? OUT_READY : 1'b1);
   assign OUT_VALID  = IN_VALID & w_primed;
`endif

   assign IN_READY = w_in_ready;
   assign PRIMED   = w_primed;

   always_ff @(posedge CLK) begin
      if (w_clr) begin
         r_fill <= 2'd0;
      end else if (w_acc && (r_fill != 2'd3)) begin
         r_fill <= r_fill + 2'd1;
      end
   end

   // One register chain per input column/row, depth equal to the row index.
   for (genvar k = 0; k < AES_NB; k++) begin : g_sr_col
      for (genvar r = 1; r <= SKEW_ROWS; r++) begin : g_sr_row
         aes128_dsp_u_skewreg #(
            .DEPTH (r)
         ) u_skewreg (
            .CLK  (CLK),
            .RST  (w_clr),
            .EN   (w_acc),
            .DIN  (DIN[col_row_lsb(k, r) +: 8]),
            .DOUT (w_sr_q[k][r-1])
         );
      end
   end

   // Output column j, row r reads input column (j - r) mod 4 of the delayed row.
   for (genvar j = 0; j < AES_NB; j++) begin : g_out_col
      assign DOUT[col_row_lsb(j, 0) +: 8] = DIN[col_row_lsb(j, 0) +: 8];
      for (genvar r = 1; r < AES_ROWS; r++) begin : g_out_row
         localparam int c_src_col = (j - r + AES_NB) % AES_NB;
         assign DOUT[col_row_lsb(j, r) +: 8] = w_sr_q[c_src_col][r-1];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes128_dsp_u_invperm.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_dsp_u_invperm
// Purpose  : Randomised and directed checks of aes128_dsp_u_invperm against a beat-history model.
// Revision : 1.0
// ============================================================================
module tb_aes128_dsp_u_invperm;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         FLUSH = 1'b0;
   logic [127:0] DIN = '0;
   logic         IN_VALID = 1'b0;
   logic         IN_READY;
   logic [127:0] DOUT;
   logic         OUT_VALID;
   logic         OUT_READY = 1'b1;
   logic         PRIMED;

   always #5 CLK = ~CLK;

   aes128_dsp_u_invperm #(
      .SKEW_ROWS (3)
   ) u_dut (
      .CLK       (CLK),
      .RST       (RST),
      .FLUSH     (FLUSH),
      .DIN       (DIN),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .DOUT      (DOUT),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .PRIMED    (PRIMED)
   );

   int           n_vec = 0;
   int           n_err = 0;
   logic [127:0] hist[$];      // last (up to 3) accepted beats since the last clear
   int           fill_cnt = 0; // accepted beats since the last clear
   logic         last_acc = 1'b0;
   logic [127:0] obs_dout;
   logic         obs_ov;
   logic         pend_v = 1'b0;
   logic [127:0] pend_d = '0;
   int           gap = 0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] get_byte(input logic [127:0] w, input int k, input int r);
      logic [127:0] t;
      t = w >> (8 * (15 - 4*k - r));
      return t[7:0];
   endfunction

   function automatic logic [127:0] model_dout(input logic [127:0] d);
      logic [127:0] res;
      logic [7:0]   b;
      res = '0;
      for (int j = 0; j < 4; j++) begin
         for (int r = 0; r < 4; r++) begin
            if (r == 0)                b = get_byte(d, j, 0);
            else if (hist.size() >= r) b = get_byte(hist[hist.size() - r], (j - r + 4) % 4, r);
            else                       b = 8'h00;
            res = res | ({120'b0, b} << (8 * (15 - 4*j - r)));
         end
      end
      return res;
   endfunction

   task automatic cycle(input logic v, input logic [127:0] d, input logic ordy,
                        input logic fl, input logic rs, input bit chk);
      logic primed, rdy, ov, acc;
      RST = rs; FLUSH = fl; IN_VALID = v; DIN = d; OUT_READY = ordy;
      @(negedge CLK);
      primed = (fill_cnt >= 3);
`ifdef AES128_INVPERM_ZERO_FILL_EN
      rdy = ordy;
      ov  = v;
`else
      rdy = primed ? ordy : 1'b1;
      ov  = v & primed;
`endif
      if (fl && !rs) rdy = 1'b0;
      acc = v & rdy;
      obs_dout = DOUT;
      obs_ov   = OUT_VALID;
      if (chk) begin
         check_eq("in_ready",  {127'b0, IN_READY},  {127'b0, rdy});
         check_eq("primed",    {127'b0, PRIMED},    {127'b0, primed});
         check_eq("out_valid", {127'b0, OUT_VALID}, {127'b0, ov});
         check_eq("dout",      DOUT,                model_dout(d));
      end
      @(posedge CLK);
      #1;
      if (rs || fl) begin
         hist.delete();
         fill_cnt = 0;
      end else if (acc) begin
         hist.push_back(d);
         if (hist.size() > 3) void'(hist.pop_front());
         if (fill_cnt < 3) fill_cnt++;
      end
      last_acc = acc;
   endtask

   function automatic logic [127:0] rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ordy_mode: 0 always ready, 1 toggling, 2 random. Upstream holds DIN while stalled.
   task automatic stream(input int ncyc, input int ordy_mode, input int bubble_max, input int clr_pct);
      for (int i = 0; i < ncyc; i++) begin
         logic v, ordy, fl, rs;
         logic [127:0] d;
         d = rand_word();
         v = 1'b1;
         if (pend_v) begin
            d = pend_d;
         end else if (gap > 0) begin
            v = 1'b0;
            gap--;
         end
         case (ordy_mode)
            0:       ordy = 1'b1;
            1:       ordy = (i % 2 == 0);
            default: ordy = ($urandom_range(0, 3) != 0);
         endcase
         rs = (clr_pct > 0) && ($urandom_range(0, 99) < clr_pct / 2);
         fl = (clr_pct > 0) && ($urandom_range(0, 99) < clr_pct);
         cycle(v, d, ordy, fl, rs, 1'b1);
         pend_v = v & ~last_acc & ~fl & ~rs;
         pend_d = d;
         if (last_acc && bubble_max > 0) gap = $urandom_range(1, bubble_max);
      end
      pend_v = 1'b0;
      gap    = 0;
   endtask

   initial begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      // Reset state with and without an input beat presented
      cycle(1'b0, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0, 1'b1);

`ifdef AES128_INVPERM_ZERO_FILL_EN
      cycle(1'b1, {128{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("zf_first_dout", obs_dout, 128'hFF000000_FF000000_FF000000_FF000000);
      check_eq("zf_first_ov",   {127'b0, obs_ov}, 128'd1);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
`endif

      cycle(1'b1, 128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 128'h10111213_14151617_18191A1B_1C1D1E1F, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 128'h20212223_24252627_28292A2B_2C2D2E2F, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 128'h30313233_34353637_38393A3B_3C3D3E3F, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("beat3_dout", obs_dout, 128'h302D1A07_34211E0B_3825120F_3C291603);
      check_eq("beat3_ov",   {127'b0, obs_ov}, 128'd1);

      stream(34, 1, 0, 0);   // OUT_READY toggling every cycle

      // FLUSH together with a valid beat while primed
      cycle(1'b1, rand_word(), 1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("flush_not_acc", {127'b0, last_acc}, 128'd0);
      for (int i = 0; i < 4; i++) cycle(1'b1, rand_word(), 1'b1, 1'b0, 1'b0, 1'b1);

      stream(60, 0, 5, 0);   // bubbles of 1-5 cycles
      stream(300, 2, 2, 4);  // random mix with occasional RST/FLUSH

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
